// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder.
// Provides the lookahead group width, the group generate/propagate pair
// type and the function that folds per-bit p/g into a group G/P.
package cla_pkg;

    localparam int unsigned GROUP_W = 4;

    // Group-level generate/propagate pair.
    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    // Fold 4-bit propagate/generate vectors into group G and P.
    function automatic gp_t group_gp(input logic [GROUP_W-1:0] p,
                                     input logic [GROUP_W-1:0] g);
        gp_t r;
        r.p = &p;
        r.g = g[3]
            | (p[3] & g[2])
            | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]);
        return r;
    endfunction

endpackage

// File: rtl/cla_group_4.sv
// Combinational 4-bit carry-lookahead group.
// Ports:
//   a_i, b_i : 4-bit operand slices
//   cin_i    : carry into bit 0 of the group
//   sum_o    : 4-bit sum slice
//   g_o, p_o : group generate / propagate (independent of cin_i)
//   cout_o   : carry out of the group
module cla_group_4
    import cla_pkg::*;
(
    input  logic [GROUP_W-1:0] a_i,
    input  logic [GROUP_W-1:0] b_i,
    input  logic               cin_i,
    output logic [GROUP_W-1:0] sum_o,
    output logic               g_o,
    output logic               p_o,
    output logic               cout_o
);

    logic [GROUP_W-1:0] p;
    logic [GROUP_W-1:0] g;
    logic [GROUP_W-1:0] c;
    gp_t                gp;

    // Per-bit terms and the group G/P are kept apart from the carry terms so
    // that G/P never depends on cin_i; the stage chains carries through G/P.
    assign p  = a_i ^ b_i;
    assign g  = a_i & b_i;
    assign gp = group_gp(p, g);

    assign g_o = gp.g;
    assign p_o = gp.p;

    // Internal lookahead carries, all flattened from cin_i.
    assign c[0] = cin_i;
    assign c[1] = g[0] | (p[0] & cin_i);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_i);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin_i);

    assign cout_o = gp.g | (gp.p & cin_i);
    assign sum_o  = p ^ c;

endmodule

// File: rtl/cla_adder_pipelined.sv
// Pipelined carry-lookahead adder with valid/ready handshake.
// The operands are cut into 4-bit lookahead groups; each of the STAGES
// register stages resolves WIDTH/4/STAGES groups and hands its carry, the
// partial sum and the unused high operand slices to the next stage.
// Latency is STAGES cycles, throughput one beat per cycle.
// Optional feature: define CLA_ADDER_SUB_EN to add sub_i (A - B with
// carry_i_i as borrow-in) and the signed-overflow flag ovf_o.
// Ports:
//   clk_i, rst_ni          : clock, async active-low reset
//   in_valid_i/in_ready_o  : input beat handshake
//   number_1_i, number_2_i : unsigned operands A and B
//   carry_i_i              : carry into bit 0
//   out_valid_o/out_ready_i: result handshake
//   sum_o                  : A + B + carry_i_i, MSB is the carry-out
//   sub_i, ovf_o           : only with CLA_ADDER_SUB_EN
module cla_adder_pipelined
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] number_1_i,
    input  logic [WIDTH-1:0] number_2_i,
    input  logic             carry_i_i,
`ifdef CLA_ADDER_SUB_EN
    input  logic             sub_i,
    output logic             ovf_o,
`endif
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH:0]   sum_o
);

    localparam int unsigned NGRP = WIDTH / GROUP_W;
    localparam int unsigned GPS  = NGRP / STAGES;
    localparam int unsigned SW   = GPS * GROUP_W;

    if ((WIDTH % GROUP_W) != 0 || STAGES == 0 || STAGES > NGRP
        || (NGRP % STAGES) != 0) begin : g_param_err
        $error("cla_adder_pipelined: illegal WIDTH/STAGES combination");
    end

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    // Operand conditioning ahead of stage 0.
`ifdef CLA_ADDER_SUB_EN
    assign b_eff   = sub_i ? ~number_2_i : number_2_i;
    assign cin_eff = carry_i_i ^ sub_i;
`else
    assign b_eff   = number_2_i;
    assign cin_eff = carry_i_i;
`endif

    // One global enable: the whole pipe moves or the whole pipe holds.
    assign adv        = !out_valid_o || out_ready_i;
    assign in_ready_o = adv;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int unsigned LO  = s * SW;
        localparam int unsigned HI  = LO + SW;
        localparam int unsigned REM = WIDTH - HI;

        logic [WIDTH-LO-1:0] a_src;
        logic [WIDTH-LO-1:0] b_src;
        logic                cin_src;
        logic                valid_src;
        logic [GPS:0]        c;
        logic [SW-1:0]       sum_slice;
        logic [GPS-1:0]      grp_g;
        logic [GPS-1:0]      grp_p;
        logic [GPS-1:0]      grp_cout;
        logic                valid_d;
        logic                valid_q;
        logic                carry_d;
        logic                carry_q;
        logic [HI-1:0]       sum_d;
        logic [HI-1:0]       sum_q;

        // Stage inputs: the raw beat for stage 0, the previous register otherwise.
        if (s == 0) begin : g_src
            assign a_src     = number_1_i;
            assign b_src     = b_eff;
            assign cin_src   = cin_eff;
            assign valid_src = in_valid_i;
            assign sum_d     = sum_slice;
        end else begin : g_src
            assign a_src     = g_stage[s-1].g_rem.a_rem_q;
            assign b_src     = g_stage[s-1].g_rem.b_rem_q;
            assign cin_src   = g_stage[s-1].carry_q;
            assign valid_src = g_stage[s-1].valid_q;
            assign sum_d     = {sum_slice, g_stage[s-1].sum_q};
        end

        for (genvar j = 0; j < GPS; j++) begin : g_grp
            cla_group_4 u_grp (
                .a_i    (a_src[j*GROUP_W +: GROUP_W]),
                .b_i    (b_src[j*GROUP_W +: GROUP_W]),
                .cin_i  (c[j]),
                .sum_o  (sum_slice[j*GROUP_W +: GROUP_W]),
                .g_o    (grp_g[j]),
                .p_o    (grp_p[j]),
                .cout_o (grp_cout[j])
            );
        end

        // Group carries chained through G/P so no carry feeds back through a group.
        always_comb begin
            c[0] = cin_src;
            for (int j = 0; j < int'(GPS); j++) begin
                c[j+1] = grp_g[j] | (grp_p[j] & c[j]);
            end
        end

        // The group's own carry-out must agree with the G/P chain.
        always_comb begin
            assert (grp_cout == c[GPS:1]);
        end

        always_comb begin
            valid_d = valid_src;
            carry_d = c[GPS];
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                sum_q   <= '0;
            end else if (adv) begin
                valid_q <= valid_d;
                carry_q <= carry_d;
                sum_q   <= sum_d;
            end
        end

        // High operand slices still waiting for a later stage.
        if (REM > 0) begin : g_rem
            logic [REM-1:0] a_rem_q;
            logic [REM-1:0] b_rem_q;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    a_rem_q <= '0;
                    b_rem_q <= '0;
                end else if (adv) begin
                    a_rem_q <= a_src[WIDTH-LO-1:SW];
                    b_rem_q <= b_src[WIDTH-LO-1:SW];
                end
            end
        end
    end

    assign out_valid_o = g_stage[STAGES-1].valid_q;
    assign sum_o       = {g_stage[STAGES-1].carry_q, g_stage[STAGES-1].sum_q};

`ifdef CLA_ADDER_SUB_EN
    logic ovf_d;
    logic ovf_q;

    // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
    always_comb begin
        ovf_d = g_stage[STAGES-1].c[GPS]
              ^ (g_stage[STAGES-1].a_src[SW-1]
               ^ g_stage[STAGES-1].b_src[SW-1]
               ^ g_stage[STAGES-1].sum_slice[SW-1]);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ovf_q <= 1'b0;
        end else if (adv) begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf_o = ovf_q;
`endif

endmodule

// File: doc/cla_adder_pipelined.md
Name: cla_adder_pipelined

Overview:
- Parametrised, pipelined carry-lookahead adder. Successor to the combinational 4-bit CLA.
- Operands are split into 4-bit lookahead groups. The carry crosses group boundaries between register stages, so WIDTH grows without a long combinational carry path.
- Uses a valid/ready handshake on input and output. Sits in the datapath between an operand source (e.g. register file/FIFO) and an accumulate or compare consumer.

Parameters:
- WIDTH, 16: operand width in bits; must be a multiple of 4.
- STAGES, 4: pipeline register stages = latency in cycles. Must divide WIDTH/4. Legal range 1..WIDTH/4.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  asynchronous reset, active-low.
- in_valid_i  input  1  operand beat valid.
- in_ready_o  output  1  block accepts a beat this cycle.
- number_1_i  input  WIDTH  operand A, unsigned.
- number_2_i  input  WIDTH  operand B, unsigned.
- carry_i_i  input  1  carry-in to bit 0.
- out_valid_o  output  1  sum_o holds a valid result.
- out_ready_i  input  1  consumer accepts the result.
- sum_o  output  WIDTH+1  A + B + carry_i_i; MSB is the carry-out.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous, active-low, on rst_ni.
- Reset state: all stage valid bits = 0, all data registers = 0. out_valid_o = 0, sum_o = 0. in_ready_o = 1 as soon as reset deasserts.
- Reset mid-operation: all in-flight beats are discarded. No partial result is ever presented.
- Group slicing:
  - G = WIDTH/4 groups, GPS = G/STAGES groups per stage.
  - Stage k (0-based) computes groups k*GPS .. k*GPS+GPS-1 with 4-bit CLA logic, chained through group carries inside the stage.
  - Stage k uses the carry registered by stage k-1. Stage 0 uses carry_i_i.
- Register contents of each stage, passed forward:
  - the partial sum bits computed so far;
  - the not-yet-used high slices of A and B;
  - the carry-out;
  - a valid bit.
- Latency: a beat accepted at edge n appears on out_valid_o/sum_o after edge n+STAGES-1, i.e. it is visible in cycle n+STAGES. With STAGES=1 the result is registered one cycle after acceptance.
- Handshake:
  - Global advance enable: adv = !out_valid_o || out_ready_i. in_ready_o = adv.
  - The beat is accepted when in_valid_i && in_ready_o.
  - When adv = 1, every stage shifts forward one position. Stage 0 loads the input beat, or a bubble (valid = 0) if none is offered.
  - When adv = 0, all stages hold. Bubbles are not collapsed.
  - Output stability: while out_valid_o = 1 and out_ready_i = 0, sum_o must hold stable.
  - in_ready_o does not depend on in_valid_i. Inputs need not be held after acceptance.
- Throughput: one beat per cycle while out_ready_i stays high.
- Arithmetic: unsigned, full WIDTH+1 result, no saturation. Wrap-around appears only as sum_o[WIDTH] = 1.
- Simultaneous events: output pop and input push in the same cycle both complete. Occupancy is unchanged.

Optional Feature:
- Macro: CLA_ADDER_SUB_EN.
- When defined:
  - Adds input sub_i (1 bit, sampled with the operands).
  - When sub_i = 1, operand B is replaced by ~B and the stage-0 carry by carry_i_i ^ 1 (two's-complement A - B, with carry_i_i = 1 meaning borrow-in).
  - sum_o[WIDTH] = 1 means no borrow.
  - Adds output ovf_o (1 bit, aligned with sum_o): signed overflow = carry into MSB XOR carry out of MSB. Reset value 0.
- When undefined: neither port exists. Behaviour is pure addition.

Decomposition:
- Package cla_pkg holds:
  - localparam GROUP_W = 4;
  - a typedef for the group generate/propagate pair;
  - a function computing group G/P from 4-bit p/g vectors.
- Sub-module cla_group_4: combinational 4-bit lookahead group.
  - Inputs: a, b, cin.
  - Outputs: 4-bit sum, group G, group P, cout.
  - Instantiated G times via generate.
- Top-level cla_adder_pipelined owns the stage registers and the handshake.

Test Plan:
- Reset, then single beat: WIDTH=16, STAGES=4, A=0x0003, B=0x0000, cin=0 → out_valid_o high exactly 4 cycles after acceptance, sum_o=0x00003.
- Full-width carry chain crossing every stage: A=0xFFFF, B=0x0001, cin=0 → sum_o=0x10000. A=0xFFFF, B=0xFFFF, cin=1 → sum_o=0x1FFFF.
- Back-to-back streaming: 8 consecutive beats (0x1111·i + 0x0101) with out_ready_i=1 → 8 results in consecutive cycles, in order, no bubbles.
- Backpressure: out_ready_i=0 for 6 cycles while 5 beats are offered → in_ready_o drops once the pipe fills, sum_o stays stable, no beat is lost or duplicated after out_ready_i=1.
- Reset mid-flight: assert rst_ni=0 with 3 beats in the pipe → out_valid_o=0 and sum_o=0 immediately, without waiting for a clock edge. No stale result after release.
- With CLA_ADDER_SUB_EN defined: sub_i=1, A=0x8000, B=0x0001, cin=0 → sum_o=0x17FFF, ovf_o=1. A=0x0005, B=0x0007 → sum_o=0x0FFFE, ovf_o=0.
